// File: rtl/asrv32_uart_tx_if.sv
// Bus-side handshake bundle for the ASRV32 UART transmitter slave.
// The master (core/decoder side) drives the request; the slave returns ack and read data.
interface asrv32_uart_tx_if;
   logic        i_stb;
   logic        i_wr_en;
   logic [31:0] i_addr;
   logic [31:0] i_data_in;
   logic [3:0]  i_wr_mask;
   logic [31:0] o_data_out;
   logic        o_ack;

   modport master (
      output i_stb, i_wr_en, i_addr, i_data_in, i_wr_mask,
      input  o_data_out, o_ack
   );

   modport slave (
      input  i_stb, i_wr_en, i_addr, i_data_in, i_wr_mask,
      output o_data_out, o_ack
   );
endinterface

// File: rtl/asrv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus-writable TX FIFO drained by a serializer.
// Registers: 0 TXDATA, 1 STATUS {ovf,busy,full,empty}, 2 DIV (bit period = DIV+1), 3 reserved.
module asrv32_uart_tx #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd15
) (
   input  logic             clk,
   input  logic             rst,
   asrv32_uart_tx_if.slave  bus,
   output logic             o_tx
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state_q;
   logic          tx_q;
   logic [7:0]    shift_q;
   logic [15:0]   timer_q;
   logic [15:0]   frame_div_q;
   logic [2:0]    bit_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   logic          ack_q, ack_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [1:0]    sel;
   logic          wr, rd, empty, full, busy, pop, push_req, push_ok;

   // Address bits outside [3:2] and data bits above the widest register are don't-care.
   logic unused_bits;
   assign unused_bits = ^{bus.i_addr[31:4], bus.i_addr[1:0], bus.i_data_in[31:16]};

   always_comb begin
      sel      = bus.i_addr[3:2];
      wr       = bus.i_stb & bus.i_wr_en;
      rd       = bus.i_stb & ~bus.i_wr_en;
      empty    = (count_q == '0);
      full     = (count_q == CNT_MAX);
      busy     = (state_q != S_IDLE);
      pop      = (state_q == S_IDLE) && !empty;
      push_req = wr && (sel == 2'd0) && bus.i_wr_mask[0];
      // A full FIFO still accepts a byte when the serializer frees a slot this cycle.
      push_ok  = push_req && (!full || pop);

      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q;
      if (wr && (sel == 2'd1) && bus.i_wr_mask[0] && bus.i_data_in[3]) ovf_d = 1'b0;
      if (push_req && !push_ok) ovf_d = 1'b1;

      div_d = div_q;
      if (wr && (sel == 2'd2)) begin
         if (bus.i_wr_mask[0]) div_d[7:0]  = bus.i_data_in[7:0];
         if (bus.i_wr_mask[1]) div_d[15:8] = bus.i_data_in[15:8];
      end

      ack_d   = bus.i_stb;
      rdata_d = '0;
      if (rd) begin
         unique case (sel)
            2'd1:    rdata_d = {28'b0, ovf_q, busy, full, empty};
            2'd2:    rdata_d = {16'b0, div_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DIV_RESET;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.i_data_in[7:0];
   end

   // Divisor is captured per frame so mid-frame DIV writes only affect the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tx_q        <= 1'b1;
         shift_q     <= '0;
         timer_q     <= '0;
         frame_div_q <= '0;
         bit_q       <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q     <= mem_q[rd_ptr_q];
                  frame_div_q <= div_q;
                  timer_q     <= div_q;
                  tx_q        <= 1'b0;
                  state_q     <= S_START;
               end
            end
            S_START: begin
               if (timer_q == '0) begin
                  timer_q <= frame_div_q;
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            S_DATA: begin
               if (timer_q == '0) begin
                  timer_q <= frame_div_q;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            S_STOP: begin
               if (timer_q == '0) state_q <= S_IDLE;
               else               timer_q <= timer_q - 16'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_tx           = tx_q;
   assign bus.o_ack      = ack_q;
   assign bus.o_data_out = rdata_q;
endmodule

// File: tb/tb_asrv32_uart_tx.sv
// Directed bench for asrv32_uart_tx: register table, frame waveform checks,
// overflow, mid-frame DIV change, mid-frame reset and back-to-back bus strobes.
module tb_asrv32_uart_tx;
   logic clk = 1'b0;
   logic rst;
   logic o_tx;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   asrv32_uart_tx_if bus_if ();

   asrv32_uart_tx #(.FIFO_DEPTH(16), .DIV_RESET(16'd15)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .o_tx (o_tx)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  off;
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_op(input logic wr, input logic [1:0] off, input logic [31:0] d,
                         input logic [3:0] m, output logic ack, output logic [31:0] rdat);
      @(negedge clk);
      bus_if.i_stb     = 1'b1;
      bus_if.i_wr_en   = wr;
      bus_if.i_addr    = {28'h0, off, 2'b00};
      bus_if.i_data_in = d;
      bus_if.i_wr_mask = m;
      @(negedge clk);
      ack              = bus_if.o_ack;
      rdat             = bus_if.o_data_out;
      bus_if.i_stb     = 1'b0;
      bus_if.i_wr_en   = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m,
                         input string name);
      logic        a;
      logic [31:0] r;
      bus_op(1'b1, off, d, m, a, r);
      chk({name, " ack"}, {31'b0, a}, 32'd1);
   endtask

   task automatic rd_chk(input logic [1:0] off, input logic [31:0] exp, input string name);
      logic        a;
      logic [31:0] r;
      bus_op(1'b0, off, 32'h0, 4'h0, a, r);
      chk({name, " ack"}, {31'b0, a}, 32'd1);
      chk(name, r, exp);
   endtask

   // Waits (bounded) for a start bit, then checks every cycle of the 10-bit frame.
   task automatic check_frame(input logic [7:0] b, input int div, input string name,
                              output int waited);
      int   n;
      int   bad;
      logic e;
      n   = 0;
      bad = 0;
      while (o_tx !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      if (o_tx !== 1'b0) begin
         chk({name, " start timeout"}, {31'b0, o_tx}, 32'd0);
         return;
      end
      for (int i = 0; i < 10; i++) begin
         e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         for (int c = 0; c <= div; c++) begin
            if (o_tx !== e) bad++;
            @(negedge clk);
         end
      end
      chk({name, " bit errors"}, bad, 0);
      chk({name, " idle after stop"}, {31'b0, o_tx}, 32'd1);
   endtask

   task automatic quiet(input int cycles, input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_tx !== 1'b1) bad++;
      end
      chk(name, bad, 0);
   endtask

   initial begin
      int          w1, w2, bad;
      logic        a [4];
      logic [31:0] r [4];

      tbl[0]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h0,    "rd txdata"};
      tbl[1]  = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h1,    "rst status"};
      tbl[2]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'hF,    "rst div"};
      tbl[3]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 4'hF, 32'h0,    "wr rsv"};
      tbl[4]  = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0,    "rd rsv"};
      tbl[5]  = '{1'b1, 2'd2, 32'h0000ABCD, 4'h1, 32'h0,    "wr div lane0"};
      tbl[6]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'hCD,   "rd div lane0"};
      tbl[7]  = '{1'b1, 2'd2, 32'h00001234, 4'h2, 32'h0,    "wr div lane1"};
      tbl[8]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h12CD, "rd div lane1"};
      tbl[9]  = '{1'b1, 2'd2, 32'hFFFF0007, 4'hF, 32'h0,    "wr div full"};
      tbl[10] = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h7,    "rd div upper0"};
      tbl[11] = '{1'b1, 2'd0, 32'h00000077, 4'hE, 32'h0,    "wr tx masked"};
      tbl[12] = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h1,    "status no push"};
      tbl[13] = '{1'b1, 2'd1, 32'h00000008, 4'h1, 32'h0,    "clr ovf idle"};

      bus_if.i_stb = 1'b0; bus_if.i_wr_en = 1'b0; bus_if.i_addr = '0;
      bus_if.i_data_in = '0; bus_if.i_wr_mask = '0;

      // Reset, with a strobe during the reset cycle that must not be acked.
      rst = 1'b1;
      @(negedge clk);
      bus_if.i_stb = 1'b1; bus_if.i_addr = 32'h4;
      @(negedge clk);
      bus_if.i_stb = 1'b0;
      rst = 1'b0;
      chk("rst ack", {31'b0, bus_if.o_ack}, 32'd0);
      chk("rst data_out", bus_if.o_data_out, 32'd0);
      chk("rst tx", {31'b0, o_tx}, 32'd1);
      @(negedge clk);
      chk("no ack for rst strobe", {31'b0, bus_if.o_ack}, 32'd0);

      for (int i = 0; i < 14; i++) begin
         bus_op(tbl[i].wr, tbl[i].off, tbl[i].d, tbl[i].m, a[0], r[0]);
         chk({tbl[i].name, " ack"}, {31'b0, a[0]}, 32'd1);
         chk(tbl[i].name, r[0], tbl[i].exp);
      end
      quiet(30, "masked write no frame");

      // Single byte at DIV=3, STATUS polled mid-frame.
      wr_reg(2'd2, 32'h3, 4'h3, "div3");
      wr_reg(2'd0, 32'h55, 4'h1, "tx55");
      fork
         check_frame(8'h55, 3, "frame55", w1);
         begin
            repeat (3) @(negedge clk);
            rd_chk(2'd1, 32'h5, "status busy");
         end
      join
      rd_chk(2'd1, 32'h1, "status after frame");

      // Mid-frame DIV change: current frame keeps 4-cycle bits, next one uses 8.
      wr_reg(2'd0, 32'h0F, 4'h1, "tx0f");
      fork
         begin
            check_frame(8'h0F, 3, "frame0f", w1);
            check_frame(8'hF0, 7, "framef0", w2);
            chk("inter-frame gap", w2, 1);
         end
         begin
            wr_reg(2'd0, 32'hF0, 4'h1, "txf0");
            wr_reg(2'd2, 32'h7, 4'h3, "div7");
         end
      join

      // Fill/overflow with 18 gapless writes at DIV=100.
      wr_reg(2'd2, 32'd100, 4'h3, "div100");
      bad = 0;
      @(negedge clk);
      for (int k = 0; k < 18; k++) begin
         bus_if.i_stb = 1'b1; bus_if.i_wr_en = 1'b1; bus_if.i_addr = 32'h0;
         bus_if.i_data_in = 32'(k + 8'h30); bus_if.i_wr_mask = 4'h1;
         @(negedge clk);
         if (bus_if.o_ack !== 1'b1) bad++;
      end
      bus_if.i_stb = 1'b0; bus_if.i_wr_en = 1'b0;
      chk("burst acks", bad, 0);
      rd_chk(2'd1, 32'hE, "status ovf full busy");
      wr_reg(2'd1, 32'h8, 4'h1, "clr ovf");
      rd_chk(2'd1, 32'h6, "status ovf cleared");

      // Reset in the middle of the start bit: line returns high and stays there.
      @(negedge clk);
      chk("tx low before rst", {31'b0, o_tx}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("tx high after rst", {31'b0, o_tx}, 32'd1);
      rst = 1'b0;
      quiet(200, "no bits after rst");
      rd_chk(2'd1, 32'h1, "status after rst");
      rd_chk(2'd2, 32'hF, "div after rst");

      // Three back-to-back strobes: write DIV, read DIV, read DIV.
      @(negedge clk);
      bus_if.i_stb = 1'b1; bus_if.i_wr_en = 1'b1; bus_if.i_addr = 32'h8;
      bus_if.i_data_in = 32'h42; bus_if.i_wr_mask = 4'hF;
      @(negedge clk);
      a[0] = bus_if.o_ack; r[0] = bus_if.o_data_out;
      bus_if.i_wr_en = 1'b0;
      @(negedge clk);
      a[1] = bus_if.o_ack; r[1] = bus_if.o_data_out;
      @(negedge clk);
      a[2] = bus_if.o_ack; r[2] = bus_if.o_data_out;
      bus_if.i_stb = 1'b0;
      @(negedge clk);
      a[3] = bus_if.o_ack;
      chk("b2b ack0", {31'b0, a[0]}, 32'd1);
      chk("b2b data0", r[0], 32'h0);
      chk("b2b ack1", {31'b0, a[1]}, 32'd1);
      chk("b2b data1", r[1], 32'h42);
      chk("b2b ack2", {31'b0, a[2]}, 32'd1);
      chk("b2b data2", r[2], 32'h42);
      chk("b2b ack drop", {31'b0, a[3]}, 32'd0);

      // DIV=0: one cycle per bit.
      wr_reg(2'd2, 32'h0, 4'h3, "div0");
      wr_reg(2'd0, 32'hA3, 4'h1, "txa3");
      check_frame(8'hA3, 0, "framea3", w1);
      rd_chk(2'd1, 32'h1, "status end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
